// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter slice.
package wb_pkg;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREG  = 32;

    // Requester slots in the req_* vectors
    localparam int unsigned REQ_ALU    = 0;
    localparam int unsigned REQ_LOAD   = 1;
    localparam int unsigned REQ_MULDIV = 2;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Width of a pointer over n requesters (never zero)
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback/issue bus between execution units, decode and the arbiter.
interface wb_arbiter_if #(
    parameter int unsigned NREQ = wb_pkg::NREQ,
    parameter int unsigned XLEN = wb_pkg::XLEN
);
    import wb_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*REG_W-1:0] req_dst;
    logic [NREQ*XLEN-1:0]  req_data;
    logic [NREQ-1:0]       req_ready;

    logic                  issue_valid;
    reg_idx_t              issue_src_a;
    reg_idx_t              issue_src_b;
    reg_idx_t              issue_dst;
    logic                  stall;

    logic                  reg_write;
    reg_idx_t              dst;
    logic [XLEN-1:0]       wb;

    // Requesters/decode side
    modport master (
        output req_valid, req_dst, req_data, issue_valid, issue_src_a, issue_src_b, issue_dst,
        input  req_ready, stall, reg_write, dst, wb
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_dst, req_data, issue_valid, issue_src_a, issue_src_b, issue_dst,
        output req_ready, stall, reg_write, dst, wb
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned NREQ  = wb_pkg::NREQ,
    parameter int unsigned PTR_W = wb_pkg::ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    int unsigned idx;
    logic        found;

    // Scan requesters in priority order starting at ptr
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant of the register-file write port plus
// a pending-write scoreboard that stalls decode on RAW/WAW hazards.
module wb_arbiter #(
    parameter int unsigned NREQ = wb_pkg::NREQ,
    parameter int unsigned XLEN = wb_pkg::XLEN
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    wb_arbiter_if.slave  bus
);
    import wb_pkg::*;

    localparam int unsigned PTR_W = ptr_width(NREQ);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  gnt;
    logic             fire;
    logic [PTR_W-1:0] win_idx;
    reg_idx_t         sel_dst;
    logic [XLEN-1:0]  sel_data;

    logic             reg_write_q;
    reg_idx_t         dst_q;
    logic [XLEN-1:0]  wb_q;

    logic [NREG-1:0]  pending_q, pending_d;
    logic             stall_w;
    logic             issue_set;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // Grants are suppressed while held in reset
    assign bus.req_ready = gnt & {NREQ{reset_n}};
    assign fire          = |(bus.req_valid & bus.req_ready);

    // Select the winner's payload and compute the next round-robin pointer
    always_comb begin
        win_idx  = '0;
        sel_dst  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_idx  = PTR_W'(i);
                sel_dst  = bus.req_dst[REG_W*i +: REG_W];
                sel_data = bus.req_data[XLEN*i +: XLEN];
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Hazard check against outstanding writes
    assign stall_w   = reset_n & bus.issue_valid &
                       (pending_q[bus.issue_src_a] | pending_q[bus.issue_src_b] |
                        pending_q[bus.issue_dst]);
    assign bus.stall = stall_w;
    assign issue_set = bus.issue_valid & ~stall_w & (bus.issue_dst != '0);

    // Scoreboard update; a new issue overrides a same-index writeback clear
    always_comb begin
        pending_d = pending_q;
        if (reg_write_q) begin
            pending_d[dst_q] = 1'b0;
        end
        if (issue_set) begin
            pending_d[bus.issue_dst] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State: pointer, scoreboard and registered writeback port
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            reg_write_q <= 1'b0;
            dst_q       <= '0;
            wb_q        <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            // x0 writes are accepted but never committed
            reg_write_q <= fire & (sel_dst != '0);
            if (fire) begin
                dst_q <= sel_dst;
                wb_q  <= sel_data;
            end
        end
    end

    assign bus.reg_write = reg_write_q;
    assign bus.dst       = dst_q;
    assign bus.wb        = wb_q;

endmodule
